// File: rtl/rr_packet_mux.sv
// N-channel packet multiplexer: a small FIFO per channel, a work-conserving
// round-robin arbiter that holds the grant for multi-word packets, and a registered output.
module rr_packet_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 35,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     next_ready,
  input  logic                     mem_full,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     pkt_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {UNLOCKED, LOCKED} arb_state_e;

  arb_state_e               state_q, state_d;
  logic [NUM_CH-1:0]        push, pop, fifo_empty;
  logic [NUM_CH*DATA_W-1:0] head_flat;
  logic [CH_W-1:0]          rr_ptr, rr_sel, rr_idx, sel;
  logic                     rr_found, slot_free, load;
  logic [DATA_W-1:0]        sel_word;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    assign in_ready[i]                      = (count != CW'(FIFO_DEPTH));
    assign fifo_empty[i]                    = (count == '0);
    assign push[i]                          = in_valid[i] & in_ready[i];
    assign head_flat[i*DATA_W +: DATA_W]    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Search starts just after the last granted channel, so a channel that
  // just finished a packet drops to lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!rr_found && !fifo_empty[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    slot_free = !out_valid || next_ready;
    state_d   = state_q;
    sel       = rr_sel;
    load      = 1'b0;
    sel_word  = '0;
    pop       = '0;
    case (state_q)
      UNLOCKED: load = slot_free && !mem_full && rr_found;
      LOCKED: begin
        sel  = grant_ch;
        load = slot_free && !fifo_empty[grant_ch];
      end
      default: load = 1'b0;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CH_W'(i)) sel_word = head_flat[i*DATA_W +: DATA_W];
    end
    if (load) begin
      pop[sel] = 1'b1;
      state_d  = sel_word[DATA_W-1] ? LOCKED : UNLOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= UNLOCKED;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      grant_ch  <= '0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      out_data  <= sel_word;
      out_valid <= 1'b1;
      grant_ch  <= sel;
      rr_ptr    <= sel;
    end else if (next_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign pkt_lock = (state_q == LOCKED);

endmodule
